// File: rtl/reg_file_pkg.sv
// Shared core constants and types for the integer register file:
// data width, register count/index width and the INIT/RUN state encoding.
package reg_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  // x0 is hardwired, so the zeroing sweep covers x1 .. x(REG_COUNT-1).
  localparam reg_idx_t SWEEP_FIRST = reg_idx_t'(1);
  localparam reg_idx_t SWEEP_LAST  = reg_idx_t'(REG_COUNT - 1);

  function automatic logic is_writable(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bundle of the register-file decode/write-back signals, with the core side
// (master) driving indices and write-back data and the file (slave) returning reads.
interface reg_file_if;
  import reg_file_pkg::*;

  xlen_t    wb_data;
  reg_idx_t wb_rd;
  logic     wb_we;
  reg_idx_t rs1_id;
  reg_idx_t rs2_id;
  xlen_t    rd1_id;
  xlen_t    rd2_id;
  logic     rf_busy;

  modport master (
    output wb_data, wb_rd, wb_we, rs1_id, rs2_id,
    input  rd1_id, rd2_id, rf_busy
  );

  modport slave (
    input  wb_data, wb_rd, wb_we, rs1_id, rs2_id,
    output rd1_id, rd2_id, rf_busy
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 integer register file with two combinational read ports, one write-back
// port with write-first bypass, and a post-reset sweep that zeroes x1..x31.
module reg_file
  import reg_file_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  xlen_t    wb_data,
  input  reg_idx_t wb_rd,
  input  logic     wb_we,
  input  reg_idx_t rs1_id,
  input  reg_idx_t rs2_id,
  output xlen_t    rd1_id,
  output xlen_t    rd2_id,
  output logic     rf_busy
);

  rf_state_e state_q, state_d;
  reg_idx_t  cnt_q, cnt_d;

  // NOTE: storage has no reset; it is cleared by the sweep through the single
  // write port so that it stays a plain distributed-RAM array.
  xlen_t mem_q [REG_COUNT];

  logic     mem_we;
  reg_idx_t mem_addr;
  xlen_t    mem_wdata;
  logic     run_wr;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= SWEEP_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + reg_idx_t'(1);
        if (cnt_q == SWEEP_LAST) begin
          state_d = RUN;
          cnt_d   = SWEEP_FIRST;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  // A cycle with rst high is treated as busy even before the state flop
  // has been forced to INIT, so the pipeline never sees stale data.
  assign rf_busy = rst || (state_q == INIT);
  assign run_wr  = (state_q == RUN) && !rst && wb_we && is_writable(wb_rd);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wb_rd;
    mem_wdata = wb_data;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else if (run_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Write-first bypass, then x0 and busy override everything.
  always_comb begin
    rd1_id = mem_q[rs1_id];
    if (run_wr && (rs1_id == wb_rd)) rd1_id = wb_data;
    if (rf_busy || !is_writable(rs1_id)) rd1_id = '0;
  end

  always_comb begin
    rd2_id = mem_q[rs2_id];
    if (run_wr && (rs2_id == wb_rd)) rd2_id = wb_data;
    if (rf_busy || !is_writable(rs2_id)) rd2_id = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed reset/sweep, write, x0, bypass
// and reset cases plus randomized traffic against an array model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk;
  logic rst;
  reg_file_if rf_bus ();

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .wb_data (rf_bus.wb_data),
    .wb_rd   (rf_bus.wb_rd),
    .wb_we   (rf_bus.wb_we),
    .rs1_id  (rf_bus.rs1_id),
    .rs2_id  (rf_bus.rs2_id),
    .rd1_id  (rf_bus.rd1_id),
    .rd2_id  (rf_bus.rd2_id),
    .rf_busy (rf_bus.rf_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [32];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] rs, input bit we,
                                            input logic [4:0] rd, input logic [31:0] data);
    if (rs == 5'd0) return 32'h0;
    if (we && rd != 5'd0 && rs == rd) return data;
    return model[rs];
  endfunction

  // One RUN cycle: drive, check combinational reads mid-cycle, commit at the edge.
  task automatic apply(input bit we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
    rf_bus.wb_we   = we;
    rf_bus.wb_rd   = rd;
    rf_bus.wb_data = data;
    rf_bus.rs1_id  = rs1;
    rf_bus.rs2_id  = rs2;
    #4;
    check({tag, "_rd1"}, rf_bus.rd1_id, expect_rd(rs1, we, rd, data));
    check({tag, "_rd2"}, rf_bus.rd2_id, expect_rd(rs2, we, rd, data));
    check({tag, "_busy"}, {31'b0, rf_bus.rf_busy}, 32'h0);
    @(posedge clk);
    if (we && rd != 5'd0) model[rd] = data;
    #1;
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst            = 1'b1;
      rf_bus.wb_we   = 1'b0;
      rf_bus.rs1_id  = 5'($urandom_range(0, 31));
      rf_bus.rs2_id  = 5'($urandom_range(0, 31));
      #4;
      check("rst_busy", {31'b0, rf_bus.rf_busy}, 32'h1);
      check("rst_rd1", rf_bus.rd1_id, 32'h0);
      check("rst_rd2", rf_bus.rd2_id, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  // Releases reset and counts busy cycles; writes driven meanwhile must vanish.
  task automatic sweep(input bit inject);
    int n;
    n   = 0;
    rst = 1'b0;
    while (rf_bus.rf_busy === 1'b1 && n < 40) begin
      if (inject && n == 9) begin
        rf_bus.wb_we   = 1'b1;
        rf_bus.wb_rd   = 5'd3;
        rf_bus.wb_data = 32'h0000FFFF;
      end else begin
        rf_bus.wb_we   = 1'($urandom_range(0, 1));
        rf_bus.wb_rd   = 5'($urandom_range(0, 31));
        rf_bus.wb_data = $urandom;
      end
      rf_bus.rs1_id = rf_bus.wb_rd;
      rf_bus.rs2_id = 5'($urandom_range(0, 31));
      #4;
      check("init_rd1", rf_bus.rd1_id, 32'h0);
      check("init_rd2", rf_bus.rd2_id, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_cycles", 32'(n), 32'd31);
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    for (int r = 1; r < 32; r++) apply(1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r), "post_sweep");
  endtask

  task automatic random_traffic(input int cycles);
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    for (int i = 0; i < cycles; i++) begin
      rd  = 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      apply(1'($urandom_range(0, 1)), rd, $urandom, rs1, rs2, "rand");
    end
  endtask

  initial begin
    rst            = 1'b1;
    rf_bus.wb_we   = 1'b0;
    rf_bus.wb_rd   = 5'd0;
    rf_bus.wb_data = 32'h0;
    rf_bus.rs1_id  = 5'd0;
    rf_bus.rs2_id  = 5'd0;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    @(posedge clk);
    #1;

    hold_reset(2);
    sweep(1'b0);

    apply(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1, "wr_x5");
    apply(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd_x5");

    apply(1'b1, 5'd0, 32'h00001234, 5'd0, 5'd0, "x0_wr");
    apply(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "x0_after");

    apply(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, "bypass");
    apply(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "bypass_hold");

    apply(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0, "wr_x3");
    hold_reset(1);
    sweep(1'b1);
    apply(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "x3_after_init");

    random_traffic(400);

    apply(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd0, "wr_x9");
    hold_reset(1);
    sweep(1'b0);
    apply(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "x9_after_reset");

    random_traffic(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
